// File: rtl/tone_pkg.sv
// Shared definitions for the square-wave tone generator: divider FSM state
// encodings, default audible frequency limits and the request range check.
package tone_pkg;

    localparam int unsigned DEF_MIN_FREQ = 20;
    localparam int unsigned DEF_MAX_FREQ = 20000;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DIV  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // True when freq lies inside the inclusive [lo, hi] band.
    function automatic logic freq_ok(input logic [31:0] freq,
                                     input logic [31:0] lo,
                                     input logic [31:0] hi);
        return (freq >= lo) && (freq <= hi);
    endfunction

endpackage

// File: rtl/seq_div_restoring.sv
// Iterative restoring divider, one quotient bit per clock, MSB first.
// Ports:
//   iClock, iReset  clock and synchronous active-high reset
//   iStart          pulse: capture iDividend/iDivisor and begin
//   iDividend       unsigned dividend (DVD_W bits)
//   iDivisor        unsigned divisor (DVS_W bits)
//   oBusy           high while quotient bits are being produced
//   oDone           one-cycle pulse once oQuot is final
//   oQuot           quotient, held until the next iStart
module seq_div_restoring #(
    parameter int unsigned DVD_W = 32,
    parameter int unsigned DVS_W = 17
) (
    input  logic             iClock,
    input  logic             iReset,
    input  logic             iStart,
    input  logic [DVD_W-1:0] iDividend,
    input  logic [DVS_W-1:0] iDivisor,
    output logic             oBusy,
    output logic             oDone,
    output logic [DVD_W-1:0] oQuot
);

    localparam int unsigned CW = $clog2(DVD_W + 1);

    logic [DVD_W-1:0] r_quot;
    logic [DVS_W-1:0] r_rem;
    logic [DVS_W-1:0] r_dvs;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;

    logic [DVS_W:0]   w_trial;
    logic [DVS_W:0]   w_diff;
    logic             w_ge;

    // Partial remainder shifted left with the next dividend bit brought in.
    assign w_trial = {r_rem, r_quot[DVD_W-1]};
    assign w_ge    = (w_trial >= {1'b0, r_dvs});
    assign w_diff  = w_trial - {1'b0, r_dvs};

    // The dividend register doubles as the quotient shift register.
    always_ff @(posedge iClock) begin
        if (iReset) begin
            r_quot <= '0;
            r_rem  <= '0;
            r_dvs  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (iStart) begin
                r_quot <= iDividend;
                r_rem  <= '0;
                r_dvs  <= iDivisor;
                r_cnt  <= CW'(DVD_W);
                r_busy <= 1'b1;
            end else if (r_busy) begin
                r_rem  <= DVS_W'(w_ge ? w_diff : w_trial);
                r_quot <= {r_quot[DVD_W-2:0], w_ge};
                r_cnt  <= r_cnt - CW'(1);
                if (r_cnt == CW'(1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign oBusy = r_busy;
    assign oDone = r_done;
    assign oQuot = r_quot;

endmodule

// File: rtl/tone_square_gen.sv
// 50%-duty square-wave tone generator fed by the score player's
// enable/frequency pair. The half-period floor(CLK_HZ/(2*freq)) is computed
// by a sequential divider; new half-periods are applied only at output edges.
// Ports:
//   iClock, iReset  clock and synchronous active-high reset
//   iEnable         tone request
//   iFreq           requested frequency in Hz
//   oAudio          square-wave output
//   oActive         generator is toggling oAudio
//   oBusy           divider is computing
module tone_square_gen
    import tone_pkg::*;
#(
    parameter int unsigned CLK_HZ   = 50000000,
    parameter int unsigned FREQ_W   = 16,
    parameter int unsigned CNT_W    = 32,
    parameter int unsigned MIN_FREQ = DEF_MIN_FREQ,
    parameter int unsigned MAX_FREQ = DEF_MAX_FREQ
) (
    input  logic              iClock,
    input  logic              iReset,
    input  logic              iEnable,
    input  logic [FREQ_W-1:0] iFreq,
    output logic              oAudio,
    output logic              oActive,
    output logic              oBusy
);

    localparam int unsigned DVS_W = FREQ_W + 1;

    logic [1:0]        r_state;
    logic [FREQ_W-1:0] r_freq_lat;
    logic [CNT_W-1:0]  r_half_per;
    logic [CNT_W-1:0]  r_pend_half;
    logic              r_pend_valid;
    logic [CNT_W-1:0]  r_counter;
    logic              r_audio;
    logic              r_active;
    logic              r_discard;

    logic [1:0]        w_next_state;
    logic              w_div_start;
    logic              w_valid;
    logic              w_silent;
    logic              w_div_busy;
    logic              w_div_done;
    logic [CNT_W-1:0]  w_quot;
    logic [DVS_W-1:0]  w_divisor;
    logic              w_terminal;

    assign w_valid    = iEnable && freq_ok(32'(iFreq), 32'(MIN_FREQ), 32'(MAX_FREQ));
    assign w_silent   = !w_valid;
    assign w_divisor  = {iFreq, 1'b0};
    assign w_terminal = (r_counter == r_half_per - CNT_W'(1));

    seq_div_restoring #(
        .DVD_W (CNT_W),
        .DVS_W (DVS_W)
    ) u_div (
        .iClock    (iClock),
        .iReset    (iReset),
        .iStart    (w_div_start),
        .iDividend (CNT_W'(CLK_HZ)),
        .iDivisor  (w_divisor),
        .oBusy     (w_div_busy),
        .oDone     (w_div_done),
        .oQuot     (w_quot)
    );

    // Divider FSM state register.
    always_ff @(posedge iClock) begin
        if (iReset) r_state <= ST_IDLE;
        else        r_state <= w_next_state;
    end

    // Divider FSM next state; a new division starts only for a changed pitch.
    always_comb begin
        w_next_state = r_state;
        w_div_start  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_valid && (iFreq != r_freq_lat)) begin
                    w_next_state = ST_DIV;
                    w_div_start  = 1'b1;
                end
            end
            ST_DIV:  if (w_div_done) w_next_state = ST_DONE;
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Frequency latch, pending half-period and square-wave generator.
    always_ff @(posedge iClock) begin
        if (iReset) begin
            r_freq_lat   <= '0;
            r_half_per   <= '0;
            r_pend_half  <= '0;
            r_pend_valid <= 1'b0;
            r_counter    <= '0;
            r_audio      <= 1'b0;
            r_active     <= 1'b0;
            r_discard    <= 1'b0;
        end else begin
            if (w_div_start) begin
                r_freq_lat <= iFreq;
                r_discard  <= 1'b0;
            end

            if (w_silent) begin
                // Clearing the latch forces a recompute on re-enable; a
                // division already running is allowed to finish unused.
                r_freq_lat   <= '0;
                r_audio      <= 1'b0;
                r_active     <= 1'b0;
                r_counter    <= '0;
                r_pend_valid <= 1'b0;
                if (r_state != ST_IDLE) r_discard <= 1'b1;
            end else if (!r_active) begin
                if (r_pend_valid) begin
                    r_half_per   <= r_pend_half;
                    r_counter    <= '0;
                    r_audio      <= 1'b1;
                    r_active     <= 1'b1;
                    r_pend_valid <= 1'b0;
                end
            end else if (w_terminal) begin
                r_audio   <= !r_audio;
                r_counter <= '0;
                if (r_pend_valid) begin
                    r_half_per   <= r_pend_half;
                    r_pend_valid <= 1'b0;
                end
            end else begin
                r_counter <= r_counter + CNT_W'(1);
            end

            // A fresh result overrides any older pending value on this edge.
            if ((r_state == ST_DONE) && !r_discard && !w_silent) begin
                r_pend_half  <= w_quot;
                r_pend_valid <= 1'b1;
            end
        end
    end

    assign oAudio  = r_audio;
    assign oActive = r_active;
    assign oBusy   = w_div_busy;

endmodule
